seg7_scan_decoder: RTL and testbench

Receive-side counterpart of the team's hex-to-7-segment encoder. It watches a multiplexed, active-low 7-segment bus (segment lines plus digit enables), filters scan transitions and glitches, and maps each stable segment pattern back to its 4-bit hex value. It stores one nibble per digit and flags any pattern that is not one of the 16 encoder codes. It sits on the processor's display path as a self-check and readback block.

---
 rtl/seg7_scan_decoder.sv | 154 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Readback decoder for a multiplexed, active-low 7-segment bus: filters scan
// transitions, maps each stable segment pattern back to its hex nibble per digit.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  update_pulse,
    output logic                  err_pulse
);

    localparam int BUS_W = DIGITS + 7;
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [BUS_W-1:0]    sync1;
    logic [BUS_W-1:0]    sync2;
    logic [BUS_W-1:0]    history;
    logic [CNT_W-1:0]    stable_cnt;
    logic                committed;

    logic                same;
    logic                commit;
    logic [6:0]          seg_s;
    logic [DIGITS-1:0]   an_s;
    logic                any_low;
    logic                multi_low;
    logic                seg_match;
    logic [3:0]          seg_code;

    logic [4*DIGITS-1:0] hex_next;
    logic [DIGITS-1:0]   valid_next;
    logic                update_next;
    logic                err_next;

    // Inverse of the encoder table; only exact codes are accepted.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h40:   decode_seg = {1'b1, 4'h0};
            7'h79:   decode_seg = {1'b1, 4'h1};
            7'h24:   decode_seg = {1'b1, 4'h2};
            7'h30:   decode_seg = {1'b1, 4'h3};
            7'h19:   decode_seg = {1'b1, 4'h4};
            7'h12:   decode_seg = {1'b1, 4'h5};
            7'h02:   decode_seg = {1'b1, 4'h6};
            7'h78:   decode_seg = {1'b1, 4'h7};
            7'h00:   decode_seg = {1'b1, 4'h8};
            7'h18:   decode_seg = {1'b1, 4'h9};
            7'h08:   decode_seg = {1'b1, 4'hA};
            7'h03:   decode_seg = {1'b1, 4'hB};
            7'h46:   decode_seg = {1'b1, 4'hC};
            7'h21:   decode_seg = {1'b1, 4'hD};
            7'h06:   decode_seg = {1'b1, 4'hE};
            7'h0E:   decode_seg = {1'b1, 4'hF};
            default: decode_seg = {1'b0, 4'h0};
        endcase
    endfunction

    // Reset value is all ones: a blank bus with no digit enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {an_in, seg_in};
            sync2 <= sync1;
        end
    end

    assign seg_s  = sync2[6:0];
    assign an_s   = sync2[BUS_W-1:7];
    assign same   = (sync2 == history);
    assign commit = same && (stable_cnt == CNT_MAX) && !committed;
    assign {seg_match, seg_code} = decode_seg(seg_s);

    // The committed flag limits each stable window to a single commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            history    <= '1;
            stable_cnt <= '0;
            committed  <= 1'b0;
        end else begin
            history <= sync2;
            if (same) begin
                if (stable_cnt != CNT_MAX) begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
                if (commit) begin
                    committed <= 1'b1;
                end
            end else begin
                stable_cnt <= '0;
                committed  <= 1'b0;
            end
        end
    end

    always_comb begin
        any_low   = 1'b0;
        multi_low = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_s[i]) begin
                multi_low = multi_low | any_low;
                any_low   = 1'b1;
            end
        end
    end

    // A blank window commits silently; overlapping enables only raise an error.
    always_comb begin
        hex_next    = hex_out;
        valid_next  = digit_valid;
        update_next = 1'b0;
        err_next    = 1'b0;
        if (commit && any_low) begin
            if (multi_low) begin
                err_next = 1'b1;
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (!an_s[i]) begin
                        if (seg_match) begin
                            hex_next[4*i +: 4] = seg_code;
                            valid_next[i]      = 1'b1;
                        end else begin
                            valid_next[i]      = 1'b0;
                        end
                    end
                end
                update_next = seg_match;
                err_next    = !seg_match;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out      <= '0;
            digit_valid  <= '0;
            update_pulse <= 1'b0;
            err_pulse    <= 1'b0;
        end else begin
            hex_out      <= hex_next;
            digit_valid  <= valid_next;
            update_pulse <= update_next;
            err_pulse    <= err_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: scripted and random bus windows, a reference
// decode model feeding a scoreboard queue, and reset checks.
module tb_seg7_scan_decoder;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;
    localparam int LAT    = STABLE + 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = 7'h7F;
    logic [3:0]  an_in = 4'hF;
    logic [15:0] hex_out;
    logic [3:0]  digit_valid;
    logic        update_pulse;
    logic        err_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          upd;
        int          err;
        logic [15:0] hex;
        logic [3:0]  valid;
    } exp_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        int         cycles;
    } stim_t;

    exp_t        sb[$];
    logic [15:0] m_hex = '0;
    logic [3:0]  m_valid = '0;
    logic [6:0]  seg_table [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_in       (seg_in),
        .an_in        (an_in),
        .hex_out      (hex_out),
        .digit_valid  (digit_valid),
        .update_pulse (update_pulse),
        .err_pulse    (err_pulse)
    );

    always #5 clk = ~clk;

    task automatic predict(input logic [3:0] an, input logic [6:0] seg, input int cycles);
        exp_t e;
        int lows = 0;
        int dig = 0;
        int code = -1;
        e.upd = 0;
        e.err = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an[i] == 1'b0) begin
                lows++;
                dig = i;
            end
        end
        for (int j = 0; j < 16; j++) begin
            if (seg_table[j] == seg) code = j;
        end
        if (cycles >= LAT) begin
            if (lows > 1) begin
                e.err = 1;
            end else if (lows == 1) begin
                if (code >= 0) begin
                    m_hex[dig*4 +: 4] = 4'(code);
                    m_valid[dig] = 1'b1;
                    e.upd = 1;
                end else begin
                    m_valid[dig] = 1'b0;
                    e.err = 1;
                end
            end
        end
        e.hex = m_hex;
        e.valid = m_valid;
        sb.push_back(e);
    endtask

    task automatic run_window(input logic [3:0] an, input logic [6:0] seg, input int cycles,
                              output int upd_n, output int err_n, output int both_n,
                              output int first_at);
        an_in = an;
        seg_in = seg;
        upd_n = 0;
        err_n = 0;
        both_n = 0;
        first_at = 0;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            if (update_pulse === 1'b1) upd_n++;
            if (err_pulse === 1'b1) err_n++;
            if (update_pulse === 1'b1 && err_pulse === 1'b1) both_n++;
            if ((update_pulse === 1'b1 || err_pulse === 1'b1) && first_at == 0) first_at = c;
        end
    endtask

    task automatic test_reset();
        int u, er, b, at;
        rst_n = 1'b0;
        an_in = 4'hF;
        seg_in = 7'h7F;
        repeat (3) @(negedge clk);
        n_checks++; if (hex_out !== 16'h0) begin n_fail++; $display("[TB] FAIL reset hex: got %h expected 0000", hex_out); end
        n_checks++; if (digit_valid !== 4'h0) begin n_fail++; $display("[TB] FAIL reset valid: got %b expected 0000", digit_valid); end
        n_checks++; if (update_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL reset update: got %b expected 0", update_pulse); end
        n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL reset err: got %b expected 0", err_pulse); end
        rst_n = 1'b1;
        m_hex = '0;
        m_valid = '0;
        run_window(4'hF, 7'h7F, 10, u, er, b, at);
        n_checks++; if (u + er !== 0) begin n_fail++; $display("[TB] FAIL reset blank pulses: got %0d expected 0", u + er); end
        n_checks++; if (hex_out !== 16'h0) begin n_fail++; $display("[TB] FAIL reset release hex: got %h expected 0000", hex_out); end
    endtask

    task automatic test_windows(input string tag, input stim_t st[]);
        exp_t e;
        int u, er, b, at;
        foreach (st[k]) begin
            predict(st[k].an, st[k].seg, st[k].cycles);
            run_window(st[k].an, st[k].seg, st[k].cycles, u, er, b, at);
            e = sb.pop_front();
            n_checks++; if (u !== e.upd) begin n_fail++; $display("[TB] FAIL %s[%0d] update count: got %0d expected %0d", tag, k, u, e.upd); end
            n_checks++; if (er !== e.err) begin n_fail++; $display("[TB] FAIL %s[%0d] err count: got %0d expected %0d", tag, k, er, e.err); end
            n_checks++; if (b !== 0) begin n_fail++; $display("[TB] FAIL %s[%0d] both pulses: got %0d expected 0", tag, k, b); end
            n_checks++; if (hex_out !== e.hex) begin n_fail++; $display("[TB] FAIL %s[%0d] hex: got %h expected %h", tag, k, hex_out, e.hex); end
            n_checks++; if (digit_valid !== e.valid) begin n_fail++; $display("[TB] FAIL %s[%0d] valid: got %b expected %b", tag, k, digit_valid, e.valid); end
            if (e.upd + e.err > 0) begin
                n_checks++; if (at !== LAT) begin n_fail++; $display("[TB] FAIL %s[%0d] latency: got %0d expected %0d", tag, k, at, LAT); end
            end
        end
    endtask

    task automatic test_valid_commit();
        stim_t st[] = '{'{4'b1110, 7'h12, 10}};
        test_windows("valid_commit", st);
    endtask

    task automatic test_glitch();
        stim_t st[] = '{'{4'hF, 7'h7F, 8}, '{4'b1110, 7'h12, 3}, '{4'hF, 7'h7F, 8},
                        '{4'b1011, 7'h02, 3}, '{4'hF, 7'h7F, 8}};
        test_windows("glitch", st);
    endtask

    task automatic test_invalid_pattern();
        stim_t st[] = '{'{4'b1110, 7'h7F, 8}, '{4'hF, 7'h7F, 4}};
        test_windows("invalid", st);
    endtask

    task automatic test_multi_enable();
        stim_t st[] = '{'{4'b1100, 7'h40, 8}, '{4'hF, 7'h7F, 4}};
        test_windows("multi_enable", st);
    endtask

    task automatic test_full_scan();
        stim_t st[] = '{'{4'b0111, 7'h08, 8}, '{4'hF, 7'h7F, 4}, '{4'b1011, 7'h30, 8},
                        '{4'hF, 7'h7F, 4}, '{4'b1101, 7'h46, 8}, '{4'hF, 7'h7F, 4},
                        '{4'b1110, 7'h18, 8}, '{4'hF, 7'h7F, 4}};
        test_windows("full_scan", st);
        n_checks++; if (hex_out !== 16'hA3C9) begin n_fail++; $display("[TB] FAIL full_scan final hex: got %h expected a3c9", hex_out); end
        n_checks++; if (digit_valid !== 4'b1111) begin n_fail++; $display("[TB] FAIL full_scan final valid: got %b expected 1111", digit_valid); end
    endtask

    task automatic test_back_to_back();
        stim_t st[] = '{'{4'b1110, 7'h40, 8}, '{4'b1110, 7'h79, 8}, '{4'b1101, 7'h79, 8},
                        '{4'b1101, 7'h7F, 8}, '{4'hF, 7'h7F, 4}};
        test_windows("back_to_back", st);
    endtask

    task automatic test_random();
        stim_t st[] = new[16];
        int dig;
        for (int k = 0; k < 16; k += 2) begin
            dig = $urandom_range(0, 3);
            st[k].an = ~(4'b0001 << dig);
            st[k].seg = ($urandom_range(0, 3) == 0) ? 7'($urandom) : seg_table[$urandom_range(0, 15)];
            st[k].cycles = 8;
            st[k+1].an = 4'hF;
            st[k+1].seg = 7'h7F;
            st[k+1].cycles = 4;
        end
        test_windows("random", st);
    endtask

    task automatic test_reset_mid();
        stim_t st[] = '{'{4'hF, 7'h7F, 8}, '{4'b0111, 7'h0E, 8}};
        an_in = 4'b1110;
        seg_in = 7'h0E;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (hex_out !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_mid async hex: got %h expected 0000", hex_out); end
        n_checks++; if (digit_valid !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_mid async valid: got %b expected 0000", digit_valid); end
        an_in = 4'hF;
        seg_in = 7'h7F;
        repeat (2) @(negedge clk);
        n_checks++; if ({update_pulse, err_pulse} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_mid held pulses: got %b expected 00", {update_pulse, err_pulse}); end
        n_checks++; if (hex_out !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_mid held hex: got %h expected 0000", hex_out); end
        rst_n = 1'b1;
        m_hex = '0;
        m_valid = '0;
        test_windows("reset_mid", st);
    endtask

    initial begin
        test_reset();
        test_valid_commit();
        test_glitch();
        test_invalid_pattern();
        test_multi_enable();
        test_full_scan();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
